// File: rtl/t_counter_pkg.sv
// Shared constants for the toggle-chain up/down counter: default width and
// direction encodings used on the up input.
package t_counter_pkg;

    localparam int unsigned TCNT_WIDTH_DEFAULT = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/t_counter_cell.sv
// t_cell: one toggle stage of the counter. Load has priority over toggle;
// the complement output is kept in its own flop so both outputs are registered.
module t_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    input  logic load,
    input  logic d,
    output logic q,
    output logic qbar
);

    logic q_r;
    logic qbar_r;

    // Stage state: async clear, then load, then toggle, else hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r    <= 1'b0;
            qbar_r <= 1'b1;
        end else if (load) begin
            q_r    <= d;
            qbar_r <= ~d;
        end else if (t) begin
            q_r    <= ~q_r;
            qbar_r <= ~qbar_r;
        end else begin
            q_r    <= q_r;
            qbar_r <= qbar_r;
        end
    end

    assign q    = q_r;
    assign qbar = qbar_r;

endmodule

// File: rtl/t_counter.sv
// t_counter: synchronous up/down counter built from a chain of t_cell stages.
// Define TCNT_LOAD_EN to add the parallel load port pair (load, d).
module t_counter
    import t_counter_pkg::*;
#(
    parameter int unsigned WIDTH = TCNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
`ifdef TCNT_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] d,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] qbar_s;
    logic [WIDTH-1:0] t_s;
    logic [WIDTH-1:0] cell_d_s;
    logic             cell_load_s;
    logic             load_s;
    logic             tc_s;
    logic             ovf_r;

    function automatic logic [WIDTH-1:0] low_mask(input int n);
        logic [WIDTH-1:0] m;
        for (int j = 0; j < int'(WIDTH); j++) begin
            m[j] = (j < n) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

`ifdef TCNT_LOAD_EN
    assign load_s = load;
`else
    assign load_s = 1'b0;
`endif

    // Clear is folded into the cells' load path with an all-zero load value
    always_comb begin
        cell_load_s = clr | load_s;
`ifdef TCNT_LOAD_EN
        cell_d_s = clr ? {WIDTH{1'b0}} : d;
`else
        cell_d_s = {WIDTH{1'b0}};
`endif
    end

    // Toggle chain: bit i flips when all lower bits are ones (up) or zeros (down)
    always_comb begin
        t_s = {WIDTH{1'b0}};
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (up == DIR_UP) begin
                t_s[i] = en & ((q_s & low_mask(i)) == low_mask(i));
            end else begin
                t_s[i] = en & ((q_s & low_mask(i)) == {WIDTH{1'b0}});
            end
        end
    end

    assign tc_s = en & ((up == DIR_UP) ? (&q_s) : (~|q_s));

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
        t_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (t_s[g]),
            .load  (cell_load_s),
            .d     (cell_d_s[g]),
            .q     (q_s[g]),
            .qbar  (qbar_s[g])
        );
    end

    // Sticky overflow: set on the wrapping edge, a load step never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (clr) begin
            ovf_r <= 1'b0;
        end else if (load_s) begin
            ovf_r <= ovf_r;
        end else if (tc_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign q    = q_s;
    assign qbar = qbar_s;
    assign tc   = tc_s;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_t_counter.sv
// Directed bench for t_counter (WIDTH = 4); load vectors run when TCNT_LOAD_EN is defined.
module tb_t_counter;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             ovf;

    int n_checks;
    int n_errors;

    t_counter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .up    (up),
        .clr   (clr),
`ifdef TCNT_LOAD_EN
        .load  (load),
        .d     (d),
`endif
        .q     (q),
        .qbar  (qbar),
        .tc    (tc),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; d = 4'h0;
        #2;
        check("rst_q", 32'(q), 32'h0);
        check("rst_qbar", 32'(qbar), 32'hF);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_tc", 32'(tc), 32'h0);
        step();
        reset = 1'b0;
        step();

        // Reset mid-count
        en = 1'b1; up = 1'b1;
        repeat (5) step();
        check("cnt5_q", 32'(q), 32'h5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_q", 32'(q), 32'h0);
        check("arst_qbar", 32'(qbar), 32'hF);
        check("arst_ovf", 32'(ovf), 32'h0);
        en = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("post_rst_q", 32'(q), 32'h0);

        // Up wrap over 16 edges
        en = 1'b1; up = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            check("up_q", 32'(q), 32'(k));
            check("up_qbar", 32'(qbar), 32'(~k & 15));
            check("up_tc", 32'(tc), (k == 15) ? 32'h1 : 32'h0);
            check("up_ovf", 32'(ovf), 32'h0);
            if (k == 15) begin
                en = 1'b0;
                #1;
                check("tc_en0", 32'(tc), 32'h0);
                en = 1'b1;
            end
            step();
        end
        check("upwrap_q", 32'(q), 32'h0);
        check("upwrap_ovf", 32'(ovf), 32'h1);

        // Down wrap from a fresh reset
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        en = 1'b1; up = 1'b0;
        #1;
        check("dn_tc0", 32'(tc), 32'h1);
        check("dn_ovf0", 32'(ovf), 32'h0);
        step();
        check("dnwrap_q", 32'(q), 32'hF);
        check("dnwrap_ovf", 32'(ovf), 32'h1);
        check("dnwrap_tc", 32'(tc), 32'h0);

        // Hold and direction change
        repeat (8) step();
        check("dn7_q", 32'(q), 32'h7);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_q", 32'(q), 32'h7);
            check("hold_tc", 32'(tc), 32'h0);
        end
        en = 1'b1; up = 1'b1;
        step();
        check("dir_up_q", 32'(q), 32'h8);
        up = 1'b0;
        step();
        check("dir_dn_q", 32'(q), 32'h7);
        up = 1'b1;
        step();
        check("dir_up2_q", 32'(q), 32'h8);

        // Clear wins over en and load
        up = 1'b0;
        repeat (5) step();
        check("pre_clr_q", 32'(q), 32'h3);
        check("pre_clr_ovf", 32'(ovf), 32'h1);
        clr = 1'b1; en = 1'b1; load = 1'b1; d = 4'h9;
        step();
        check("clr_q", 32'(q), 32'h0);
        check("clr_ovf", 32'(ovf), 32'h0);
        clr = 1'b0; load = 1'b0; en = 1'b0;

`ifdef TCNT_LOAD_EN
        // Parallel load, then count through the wrap
        load = 1'b1; d = 4'hE; en = 1'b1; up = 1'b1;
        step();
        check("ld_q", 32'(q), 32'hE);
        check("ld_ovf", 32'(ovf), 32'h0);
        load = 1'b0;
        step();
        check("ld_cnt_q", 32'(q), 32'hF);
        check("ld_cnt_tc", 32'(tc), 32'h1);
        step();
        check("ld_wrap_q", 32'(q), 32'h0);
        check("ld_wrap_ovf", 32'(ovf), 32'h1);
        load = 1'b1; d = 4'h5;
        step();
        check("ld2_q", 32'(q), 32'h5);
        check("ld2_ovf", 32'(ovf), 32'h1);
        load = 1'b0; en = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/t_counter.md
# t_counter

Synchronous up/down binary counter built as a chain of toggle stages: each bit is a T flip-flop whose toggle input is generated from the lower bits. The counter supplies the toggle enables that a single T stage needs and registers the resulting count, terminal-count and sticky overflow state. It sits directly downstream of the single-bit toggle flip-flop and is the first multi-bit sequential consumer of it in the design.

## Interface
- WIDTH, 4, number of toggle stages / count bits (≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- clr  input  1  synchronous clear of count and overflow flag
- load  input  1  synchronous parallel load (present only with TCNT_LOAD_EN)
- d  input  WIDTH  load value (present only with TCNT_LOAD_EN)
- q  output  WIDTH  current count
- qbar  output  WIDTH  bitwise complement of q, always ~q
- tc  output  1  terminal count: en & (up ? q == all-ones : q == 0), combinational
- ovf  output  1  sticky wrap flag, registered

## Operation
- Bit i toggle input: t[0] = en; for i > 0, t[i] = en & (up ? &q[i-1:0] : ~|q[i-1:0]).
- Each stage: next q[i] = q[i] ^ t[i] (T flip-flop behaviour).
- Priority per cycle: reset > clr > load > en.
- clr = 1: q ← 0, ovf ← 0 next edge, regardless of en/load.
- load = 1 (clr = 0): q ← d next edge; ovf unchanged; en ignored that cycle.
- en = 1, no clr/load: q ← q+1 (up) or q−1 (down), modulo 2^WIDTH.
- Wrap-around: up from all-ones → 0, down from 0 → all-ones; both set ovf ← 1 on the same edge. ovf stays 1 until clr or reset.
- en = 0: q holds; tc = 0.
- up may change every cycle; direction sampled on the same edge as en.
- Arithmetic is unsigned WIDTH bits; no saturation.

## Timing
- Reset values: q = 0, qbar = all-ones, ovf = 0, tc = 0 (en low in reset) .
- reset asserts asynchronously mid-count: q and ovf clear immediately, without waiting for clk; first count step occurs on the first rising edge after reset deasserts with en = 1.
- Count latency: one cycle from en sample to new q.
- tc is combinational from q, en, up; valid in the cycle before the wrapping edge.
- ovf rises on the same edge that q wraps (visible one cycle after tc was high).
- clr/load take effect on the next rising edge; no multi-cycle handshake.

## Configuration
- TCNT_LOAD_EN defined: load and d ports exist; parallel load behaves as above.
- TCNT_LOAD_EN undefined: load and d ports absent; priority reduces to reset > clr > en; all other behaviour identical.

## Structure
- Shared package t_counter_pkg: default WIDTH constant, direction constants DIR_UP = 1, DIR_DOWN = 0.
- One sub-module t_cell: single toggle stage (inputs t, clk, reset, load, d; outputs q, qbar), async active-high reset to q = 0; instantiated WIDTH times via generate. Toggle-chain logic stays in t_counter.

## Test plan
- Reset mid-count: WIDTH = 4, count up to 5, assert reset between edges → q = 0, qbar = 4'hF, ovf = 0 immediately.
- Up wrap: en = 1, up = 1 from 0 for 16 cycles → q runs 0…15, tc = 1 while q = 15, q = 0 and ovf = 1 after 16th edge.
- Down wrap: from reset, en = 1, up = 0 → q = 15 after first edge, ovf = 1; tc = 1 in the cycle q was 0.
- Hold and direction change: q = 7, en = 0 for 3 cycles → q stays 7; en = 1, up alternating 1,0,1 → q = 8, 7, 8.
- Clear priority: ovf = 1, q = 3, assert clr with en = 1 (and load = 1, d = 9 when TCNT_LOAD_EN) → q = 0, ovf = 0 next edge.
- Load (TCNT_LOAD_EN): load = 1, d = 4'hE, en = 1 → q = 14 next edge; then en, up = 1 → 15 with tc = 1, then 0 with ovf = 1.
